alu_iter_cc: RTL and testbench
==============================

Name: alu_iter_cc

Overview:
- Parametrised, registered successor of the single-cycle execute-stage ALU.
- Supports width-generic add/sub/and/xor, arithmetic and logical shifts, and an iterative signed multiply (low WIDTH bits).
- Holds the condition-code register (ZF/SF/OF) internally; update is gated per operation by set_cc.
- Sits between decode/register-read and write-back; uses a valid/ready input handshake and a one-cycle result-valid pulse.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  3  000 add, 001 sub, 010 and, 011 xor, 100 mul, 101 sal, 110 sar, 111 shr.
- inp1  in  WIDTH  operand A (signed).
- inp2  in  WIDTH  operand B (signed); shift amount = inp2[SHW-1:0].
- set_cc  in  1  update CC when this op completes.
- out  out  WIDTH  registered result; holds until the next completion.
- out_valid  out  1  one-cycle pulse, result completed.
- cc  out  3  {ZF, SF, OF} register; bit2 ZF, bit1 SF, bit0 OF.
- busy  out  1  multiply in progress (equals ~in_ready).

Behaviour:
- Reset (async, immediate): out=0, out_valid=0, cc=3'b100, state=IDLE, in_ready=1, multiplier registers cleared.
- Accept condition: in_valid && in_ready at a rising edge; op, operands and set_cc are captured at that edge.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0.
  - No other states.
- Single-cycle ops (add, sub, and, xor, sal, sar, shr), accepted at edge t:
  - out, out_valid=1 and cc (if set_cc) are updated at edge t.
  - Back-to-back acceptance every cycle is allowed.
  - out_valid drops on any edge with no completion.
- Arithmetic:
  - add = inp1+inp2; sub = inp1-inp2; both modulo 2^WIDTH.
  - OF = signed overflow (carry into MSB xor carry out of MSB).
  - and, xor, shifts, mul: OF=0.
  - sal: logical left shift. sar: sign-filling right shift. shr: zero-filling right shift.
  - Shift amount 0 returns inp1 unchanged.
- Flags: ZF = (result==0); SF = result[WIDTH-1].
- mul, accepted at edge t:
  - At edge t: state->MUL; load mcand=inp1, mplier=inp2, acc=0, count=0.
  - At edges t+1..t+WIDTH, one shift-add step per edge: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; count++.
  - At edge t+WIDTH: final acc goes to out, out_valid=1, cc updated if latched set_cc, state->IDLE.
  - Result is the low WIDTH bits of the two's-complement product; unsigned shift-add is exact modulo 2^WIDTH.
- Busy rules:
  - in_valid while in MUL is ignored: not queued, no response.
  - out and cc hold their previous values throughout MUL.
- set_cc=0: cc unchanged; out and out_valid still update.
- Reset mid-multiply: aborts the operation; no out_valid; state=IDLE.
- X on op while in_valid=0: no effect.

Decomposition:
- Package alu_pkg holds:
  - op codes (ALU_ADD..ALU_SHR);
  - CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0);
  - CC_RESET=3'b100;
  - state enum {ST_IDLE, ST_MUL}.
- One sub-module, iter_mul: start pulse, operands, WIDTH-cycle shift-add datapath, done pulse, product.
- The top level holds the combinational ops, flag generation, result/CC registers and handshake.

Test Plan (WIDTH=64):
- add 0x7FFFFFFFFFFFFFFF + 1, set_cc=1 -> after next edge: out=0x8000000000000000, out_valid pulse, cc=3'b010 with OF=1, i.e. cc=3'b011.
- sub 5-5, set_cc=0, preceded by reset -> out=0, out_valid=1, cc remains 3'b100; repeat with set_cc=1 -> cc=3'b100.
- mul -3*7 accepted at edge t -> in_ready=0 for edges t+1..t+63; at edge t+64: out=0xFFFFFFFFFFFFFFEB, cc=3'b010; in_valid pulses during busy produce no extra out_valid.
- sar 0x8000000000000000 by inp2=0x44 (amount 4) -> 0xF800000000000000; shr same -> 0x0800000000000000; sal 1 by 0 -> 1.
- Back-to-back: and 0xF0F0 & 0xFF00, then xor 0xFF ^ 0xFF on consecutive edges -> out 0xF000 then 0 with ZF=1; out_valid high two consecutive cycles.
- Assert rst at edge t+10 of a mul -> out=0, out_valid=0, cc=3'b100, in_ready=1 immediately; a new add 2+2 then gives out=4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: op codes,
// condition-code layout and the handshake FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SAL = 3'b101;
  localparam logic [2:0] ALU_SAR = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/iter_mul.sv
// Shift-add multiplier: one partial product per clock, WIDTH steps after start.
// done is a combinational pulse during the last step; product is the value acc takes at that edge.
module iter_mul #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   count;
  logic             running;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = running && (count == LAST_STEP);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= mcand_in;
      mplier  <= mplier_in;
      acc     <= '0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + 1'b1;
      if (count == LAST_STEP) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iter_cc.sv
// Registered execute-stage ALU with condition codes; single-cycle ops complete
// on the accepting edge, multiply blocks new requests for WIDTH cycles.
module alu_iter_cc #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             set_cc,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       cc,
  output logic             busy
);

  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  state_e           state;
  state_e           state_next;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic             mul_set_cc;
  logic             complete;
  logic             cc_we;
  logic [WIDTH-1:0] res_sel;
  logic             of_sel;

  assign shamt    = inp2[SHW-1:0];
  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = inp1 + inp2;
        alu_of  = (inp1[MSB] == inp2[MSB]) && (alu_res[MSB] != inp1[MSB]);
      end
      ALU_SUB: begin
        alu_res = inp1 - inp2;
        alu_of  = (inp1[MSB] != inp2[MSB]) && (alu_res[MSB] != inp1[MSB]);
      end
      ALU_AND: alu_res = inp1 & inp2;
      ALU_XOR: alu_res = inp1 ^ inp2;
      ALU_SAL: alu_res = inp1 << shamt;
      ALU_SAR: alu_res = $signed(inp1) >>> shamt;
      ALU_SHR: alu_res = inp1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Selects what completes this cycle: an accepted single-cycle op or the multiplier.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    complete   = 1'b0;
    cc_we      = 1'b0;
    res_sel    = alu_res;
    of_sel     = alu_of;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == ALU_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else begin
            complete = 1'b1;
            cc_we    = set_cc;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          complete   = 1'b1;
          cc_we      = mul_set_cc;
          res_sel    = mul_product;
          of_sel     = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out        <= '0;
      out_valid  <= 1'b0;
      cc         <= CC_RESET;
      mul_set_cc <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= complete;
      if (complete) begin
        out <= res_sel;
      end
      if (cc_we) begin
        cc[CC_ZF] <= (res_sel == '0);
        cc[CC_SF] <= res_sel[MSB];
        cc[CC_OF] <= of_sel;
      end
      if (mul_start) begin
        mul_set_cc <= set_cc;
      end
    end
  end

  iter_mul #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_iter_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .mcand_in (inp1),
    .mplier_in(inp2),
    .done     (mul_done),
    .product  (mul_product)
  );

endmodule

// File: tb/tb_alu_iter_cc.sv
// Self-checking bench for alu_iter_cc: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_alu_iter_cc;

  localparam int W = 64;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SAL = 3'b101;
  localparam logic [2:0] OP_SAR = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] inp1;
  logic [W-1:0] inp2;
  logic         set_cc;
  logic [W-1:0] out;
  logic         out_valid;
  logic [2:0]   cc;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] ref_out;
  logic [2:0]   ref_cc;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sc;
    logic [W-1:0] exp_out;
    logic [2:0]   exp_cc;
  } vec_t;

  vec_t tbl[8];

  alu_iter_cc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .inp1     (inp1),
    .inp2     (inp2),
    .set_cc   (set_cc),
    .out      (out),
    .out_valid(out_valid),
    .cc       (cc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic of);
    logic signed [W:0] wide;
    int amt;
    amt = int'(b % W);
    of  = 1'b0;
    res = '0;
    case (o)
      OP_ADD: begin
        wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
        res  = wide[W-1:0];
        of   = wide[W] != wide[W-1];
      end
      OP_SUB: begin
        wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
        res  = wide[W-1:0];
        of   = wide[W] != wide[W-1];
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_MUL: res = a * b;
      OP_SAL: res = a << amt;
      OP_SAR: res = $signed(a) >>> amt;
      OP_SHR: res = a >> amt;
      default: res = '0;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
    logic [W-1:0] r;
    logic of;
    model(o, a, b, r, of);
    ref_out = r;
    if (sc) ref_cc = {r == '0, r[W-1], of};
  endtask

  // Issues one op at a negedge and waits (bounded) for its completion, then checks it.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sc, input string tag);
    int n;
    in_valid = 1'b1;
    op       = o;
    inp1     = a;
    inp2     = b;
    set_cc   = sc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 3'bxxx;
    model_apply(o, a, b, sc);
    if (o == OP_MUL) begin
      checkOutput({tag, "_busy"}, W'(busy), W'(1'b1));
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput({tag, "_mul_latency"}, W'(n), W'(64));
    end
    checkOutput({tag, "_valid"}, W'(out_valid), W'(1'b1));
    checkOutput({tag, "_out"}, out, ref_out);
    checkOutput({tag, "_cc"}, W'(cc), W'(ref_cc));
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, W'(out_valid), W'(1'b0));
    checkOutput({tag, "_ready"}, W'(in_ready), W'(1'b1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_out = '0;
    ref_cc  = 3'b100;
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      4: v = W'($urandom_range(0, 100));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = OP_ADD;
    inp1     = '0;
    inp2     = '0;
    set_cc   = 1'b0;
    ref_out  = '0;
    ref_cc   = 3'b100;

    tbl[0] = '{OP_SUB, 64'd5, 64'd5, 1'b0, 64'd0, 3'b100};
    tbl[1] = '{OP_SUB, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100};
    tbl[2] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 3'b011};
    tbl[3] = '{OP_SAR, 64'h8000_0000_0000_0000, 64'h44, 1'b1, 64'hF800_0000_0000_0000, 3'b010};
    tbl[4] = '{OP_SHR, 64'h8000_0000_0000_0000, 64'h44, 1'b1, 64'h0800_0000_0000_0000, 3'b000};
    tbl[5] = '{OP_SAL, 64'd1, 64'd0, 1'b1, 64'd1, 3'b000};
    tbl[6] = '{OP_AND, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 3'b000};
    tbl[7] = '{OP_XOR, 64'hFF, 64'hFF, 1'b1, 64'd0, 3'b100};

    do_reset();
    checkOutput("reset_out", out, '0);
    checkOutput("reset_valid", W'(out_valid), W'(1'b0));
    checkOutput("reset_cc", W'(cc), W'(3'b100));
    checkOutput("reset_ready", W'(in_ready), W'(1'b1));
    checkOutput("reset_busy", W'(busy), W'(1'b0));

    // Back-to-back table: a new vector is presented every cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      op       = tbl[i].op;
      inp1     = tbl[i].a;
      inp2     = tbl[i].b;
      set_cc   = tbl[i].sc;
      @(posedge clk);
      @(negedge clk);
      model_apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sc);
      checkOutput($sformatf("tbl%0d_valid", i), W'(out_valid), W'(1'b1));
      checkOutput($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      checkOutput($sformatf("tbl%0d_cc", i), W'(cc), W'(tbl[i].exp_cc));
      checkOutput($sformatf("tbl%0d_model", i), tbl[i].exp_out, ref_out);
    end
    in_valid = 1'b0;
    op       = 3'bxxx;
    @(negedge clk);
    checkOutput("tbl_valid_drop", W'(out_valid), W'(1'b0));
    checkOutput("tbl_out_hold", out, ref_out);

    // Multiply -3*7 with request pulses ignored while busy.
    in_valid = 1'b1;
    op       = OP_MUL;
    inp1     = -64'sd3;
    inp2     = 64'd7;
    set_cc   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mul_ready_t0", W'(in_ready), W'(1'b0));
    for (int k = 1; k < 64; k++) begin
      in_valid = (k % 3 == 0);
      op       = OP_ADD;
      inp1     = W'(k);
      inp2     = 64'd1;
      set_cc   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("mul_ready_%0d", k), W'(in_ready), W'(1'b0));
      checkOutput($sformatf("mul_novalid_%0d", k), W'(out_valid), W'(1'b0));
      checkOutput($sformatf("mul_out_hold_%0d", k), out, ref_out);
      checkOutput($sformatf("mul_cc_hold_%0d", k), W'(cc), W'(ref_cc));
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_apply(OP_MUL, -64'sd3, 64'd7, 1'b1);
    checkOutput("mul_done_valid", W'(out_valid), W'(1'b1));
    checkOutput("mul_done_out", out, 64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("mul_done_cc", W'(cc), W'(3'b010));
    checkOutput("mul_model", ref_out, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    checkOutput("mul_valid_drop", W'(out_valid), W'(1'b0));
    checkOutput("mul_ready_back", W'(in_ready), W'(1'b1));

    // Reset ten edges into a multiply.
    applyStimulus(OP_ADD, 64'd9, 64'd1, 1'b1, "pre_abort");
    in_valid = 1'b1;
    op       = OP_MUL;
    inp1     = 64'd12345;
    inp2     = 64'd678;
    set_cc   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out", out, '0);
    checkOutput("abort_valid", W'(out_valid), W'(1'b0));
    checkOutput("abort_cc", W'(cc), W'(3'b100));
    checkOutput("abort_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);
    rst     = 1'b0;
    ref_out = '0;
    ref_cc  = 3'b100;
    @(negedge clk);
    checkOutput("abort_no_late_valid", W'(out_valid), W'(1'b0));
    applyStimulus(OP_ADD, 64'd2, 64'd2, 1'b1, "post_abort_add");
    checkOutput("post_abort_four", out, 64'd4);

    // Randomized ops against the reference model.
    for (int i = 0; i < 120; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      if (ro == OP_MUL && ($urandom_range(0, 2) != 0)) ro = OP_XOR;
      applyStimulus(ro, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
